// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the sprite compositor: pixel colour struct,
// game state encoding, default colours/limits and screen geometry.
package sprite_compositor_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam logic [23:0] BG_COLOR_DEF  = 24'h1E3C78;
  localparam logic [15:0] SCORE_MAX_DEF = 16'd9999;

  localparam int unsigned SCREEN_W = 1280;
  localparam int unsigned SCREEN_H = 720;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream bundle between the sprite renderers and the compositor:
// per-layer colour/hit, raster position and syncs in, composited pixel out.
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4
);
  logic [15:0]              i_x;
  logic [15:0]              i_y;
  logic                     i_h_sync;
  logic                     i_v_sync;
  logic                     i_de;
  logic [24*NUM_LAYERS-1:0] i_layer_rgb;
  logic [NUM_LAYERS-1:0]    i_layer_hit;
  logic                     i_coin_scored;
  logic [7:0]               o_red;
  logic [7:0]               o_green;
  logic [7:0]               o_blue;
  logic                     o_h_sync;
  logic                     o_v_sync;
  logic                     o_de;

  // Renderer / video-source side.
  modport master (
    output i_x, i_y, i_h_sync, i_v_sync, i_de,
    output i_layer_rgb, i_layer_hit, i_coin_scored,
    input  o_red, o_green, o_blue, o_h_sync, o_v_sync, o_de
  );

  // Compositor side.
  modport slave (
    input  i_x, i_y, i_h_sync, i_v_sync, i_de,
    input  i_layer_rgb, i_layer_hit, i_coin_scored,
    output o_red, o_green, o_blue, o_h_sync, o_v_sync, o_de
  );
endinterface

// File: rtl/sprite_compositor_layer_priority_mux.sv
// Combinational layer select: the lowest-index layer that hits wins,
// background colour when no layer is opaque. Non-hit colours never propagate.
module layer_priority_mux
  import sprite_compositor_pkg::*;
#(
  parameter int          NUM_LAYERS = 4,
  parameter logic [23:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic [24*NUM_LAYERS-1:0] i_rgb,
  input  logic [NUM_LAYERS-1:0]    i_hit,
  output rgb_t                     o_rgb
);

  // Scan from lowest to highest priority so the last assignment is the winner.
  always_comb begin
    o_rgb = rgb_t'(BG_COLOR);
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (i_hit[k]) begin
        o_rgb = rgb_t'(i_rgb[24*k +: 24]);
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Final compositing stage: two-cycle pixel pipeline with aligned syncs,
// per-frame penguin/obstacle collision, coin scoring and IDLE/PLAY/DEAD state.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int                    NUM_LAYERS    = 4,
  parameter logic [NUM_LAYERS-1:0] OBSTACLE_MASK = 4'b0110,
  parameter logic [23:0]           BG_COLOR      = BG_COLOR_DEF,
  parameter logic [15:0]           SCORE_MAX     = SCORE_MAX_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sprite_compositor_if.slave    bus,
  input  logic                  i_start,
  output logic                  o_is_dead,
  output logic                  o_is_finished,
  output logic [15:0]           o_score
);

  logic [24*NUM_LAYERS-1:0] r_rgb_p1;
  logic [NUM_LAYERS-1:0]    r_hit_p1;
  logic                     r_vld_p1;
  logic                     r_hs_p1;
  logic                     r_vs_p1;
  logic                     r_onscr_p1;
  rgb_t                     r_pix_p2;
  logic                     r_vld_p2;
  logic                     r_hs_p2;
  logic                     r_vs_p2;

  rgb_t                     w_mux_rgb;
  logic                     w_onscr;

  logic                     r_vs_prev;
  logic                     w_frame_tick;
  logic                     r_frame_coll;
  logic                     w_coll_pix;
  logic                     r_scored_q;
  logic                     r_primed;
  logic                     w_coin_edge;
  logic [15:0]              r_score;
  game_state_t              r_state;
  game_state_t              w_state_nxt;
  logic                     w_start_play;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v < SCORE_MAX) ? v + 16'd1 : SCORE_MAX;
  endfunction

  // Hits reported outside the visible raster are never treated as collisions.
  assign w_onscr = (bus.i_x < 16'(SCREEN_W)) && (bus.i_y < 16'(SCREEN_H));

  // Stage 1: capture layer colours, hits, enable and syncs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb_p1   <= '0;
      r_hit_p1   <= '0;
      r_vld_p1   <= 1'b0;
      r_hs_p1    <= 1'b0;
      r_vs_p1    <= 1'b0;
      r_onscr_p1 <= 1'b0;
    end else begin
      r_rgb_p1   <= bus.i_layer_rgb;
      r_hit_p1   <= bus.i_layer_hit;
      r_vld_p1   <= bus.i_de;
      r_hs_p1    <= bus.i_h_sync;
      r_vs_p1    <= bus.i_v_sync;
      r_onscr_p1 <= w_onscr;
    end
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .BG_COLOR   (BG_COLOR)
  ) u_mux (
    .i_rgb (r_rgb_p1),
    .i_hit (r_hit_p1),
    .o_rgb (w_mux_rgb)
  );

  // Stage 2: register the selected colour, blanked outside active video.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_p2 <= '0;
      r_vld_p2 <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
    end else begin
      r_pix_p2 <= r_vld_p1 ? w_mux_rgb : '0;
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
    end
  end

  assign bus.o_red    = r_pix_p2.r;
  assign bus.o_green  = r_pix_p2.g;
  assign bus.o_blue   = r_pix_p2.b;
  assign bus.o_h_sync = r_hs_p2;
  assign bus.o_v_sync = r_vs_p2;
  assign bus.o_de     = r_vld_p2;

  assign w_frame_tick = bus.i_v_sync & ~r_vs_prev;
  assign w_coll_pix   = (r_state == PLAY) & r_vld_p1 & r_onscr_p1 & r_hit_p1[0]
                        & (|(r_hit_p1 & OBSTACLE_MASK));
  // The first tick after reset only loads r_scored_q, so it can never score.
  assign w_coin_edge  = w_frame_tick & r_primed & bus.i_coin_scored & ~r_scored_q;

  // Game state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; i_start is only honoured outside PLAY.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_play = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt  = PLAY;
          w_start_play = 1'b1;
        end
      end
      PLAY: begin
        if (w_frame_tick && r_frame_coll) begin
          w_state_nxt = DEAD;
        end
      end
      DEAD: begin
        if (i_start) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame bookkeeping: v_sync edge detect, collision flag, coin level and score.
  // A collision pixel on the tick cycle seeds the next frame's flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev    <= 1'b0;
      r_frame_coll <= 1'b0;
      r_scored_q   <= 1'b0;
      r_primed     <= 1'b0;
      r_score      <= 16'd0;
    end else begin
      r_vs_prev <= bus.i_v_sync;

      if (w_start_play) begin
        r_frame_coll <= 1'b0;
      end else if (w_frame_tick) begin
        r_frame_coll <= w_coll_pix;
      end else if (w_coll_pix) begin
        r_frame_coll <= 1'b1;
      end

      if (w_frame_tick) begin
        r_scored_q <= bus.i_coin_scored;
        r_primed   <= 1'b1;
      end

      if (w_start_play) begin
        r_score <= 16'd0;
      end else if ((r_state == PLAY) && w_coin_edge) begin
        r_score <= sat_inc(r_score);
      end
    end
  end

  assign o_is_dead     = (r_state == DEAD);
  assign o_is_finished = (r_state == IDLE);
  assign o_score       = r_score;

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream stage of the per-sprite renderers (coin, obstacle and penguin layers); consumes their rgb, hit and scored outputs for the current pixel.
- Merges the layers by fixed priority over a background colour and drives the final pixel with syncs re-aligned.
- Performs per-frame penguin/obstacle collision detection and keeps the score.
- Owns the play/dead game state that is fed back to every sprite's i_is_dead input.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 is the penguin, lower index = higher priority.
- OBSTACLE_MASK, 4'b0110, bit k set = layer k is lethal on overlap with layer 0.
- BG_COLOR, 24'h1E_3C_78, background RGB {r,g,b}.
- SCORE_MAX, 16'd9999, score saturation value.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_x  in  16  current pixel column.
- i_y  in  16  current pixel row.
- i_h_sync  in  1  horizontal sync, active high.
- i_v_sync  in  1  vertical sync, active high.
- i_de  in  1  active-video enable.
- i_layer_rgb  in  24*NUM_LAYERS  layer k colour at bits [24k+23:24k], ordered {r,g,b}.
- i_layer_hit  in  NUM_LAYERS  layer k opaque at this pixel.
- i_coin_scored  in  1  OR of all coin o_scored levels.
- i_start  in  1  start/restart request, single-cycle pulse.
- o_red  out  8  composited red.
- o_green  out  8  composited green.
- o_blue  out  8  composited blue.
- o_h_sync  out  1  i_h_sync delayed 2 cycles.
- o_v_sync  out  1  i_v_sync delayed 2 cycles.
- o_de  out  1  i_de delayed 2 cycles.
- o_is_dead  out  1  high in state DEAD.
- o_is_finished  out  1  high in state IDLE (sprites frozen).
- o_score  out  16  coins collected.

Behaviour:
- Reset (async assert, sync release):
  - o_red/o_green/o_blue = 0; o_h_sync, o_v_sync, o_de = 0.
  - o_score = 0; o_is_dead = 0; o_is_finished = 1; state = IDLE.
  - All pipeline registers, frame flags and edge detectors = 0.
- Pixel pipeline, fixed latency 2 cycles:
  - Stage 1 registers rgb, hit and de.
  - Stage 2 selects the lowest-index k with hit[k]=1. If no layer hits, BG_COLOR. If de=0, output 0.
  - Syncs and de pass through the same 2 register stages, so colour and syncs stay aligned.
  - No X values ever reach the outputs: non-hit layer rgb is ignored.
- Frame boundary: the rising edge of i_v_sync detected in the i_clk domain (previous-value register) produces frame_tick.
- Collision:
  - During PLAY, while stage-1 de=1, hit[0]=1 and (hit & OBSTACLE_MASK) != 0, set frame_coll.
  - frame_coll is sampled and cleared on frame_tick. If a frame_tick and a collision pixel fall on the same cycle, the collision belongs to the next frame.
- Score:
  - On each frame_tick, sample i_coin_scored into scored_q.
  - Increment o_score by 1 when scored_q goes 0->1 between consecutive frame_ticks and state = PLAY.
  - o_score saturates at SCORE_MAX; a level held over many frames counts once.
- FSM states IDLE, PLAY, DEAD:
  - IDLE -> PLAY on i_start; o_score cleared in the same cycle.
  - PLAY -> DEAD on frame_tick with frame_coll=1. A coin edge on that same tick is still counted.
  - DEAD -> IDLE on i_start. i_start is ignored in PLAY.
  - i_start coinciding with frame_tick: the state transition takes precedence; collision evaluation is skipped for that tick.
- Reset mid-frame: outputs go to reset values immediately; the first frame_tick after release only primes the edge detectors and never scores.
- Widths: all comparisons are unsigned; the score increment is compared against SCORE_MAX before adding.

Decomposition:
- Shared package holds:
  - rgb_t, a struct {r,g,b} of 8 bits each;
  - game_state_t, an enum IDLE/PLAY/DEAD;
  - BG_COLOR and SCORE_MAX defaults, and the screen constants 1280x720.
- One natural sub-module, layer_priority_mux: a combinational lowest-index-hit select with background fallback. It sits between the two pipeline registers.

Test Plan:
- Layer 2 hit with rgb 24'hFFDB00 and layer 1 hit with 24'h112233 at de=1 -> 2 cycles later output 11/22/33. With no hits -> 1E/3C/78. With de=0 -> 00/00/00.
- i_h_sync/i_v_sync/i_de toggled at known cycles -> outputs identical waveform shifted by exactly 2 clocks.
- IDLE, i_start pulse, then i_coin_scored held high for 3 frames -> o_score=1. Dropped for 1 frame and raised again -> o_score=2.
- PLAY, one pixel with hit=4'b0011 in frame N -> o_is_dead=1 after frame_tick N+1. An overlap of hit=4'b1001 (layer 3 not in mask) -> remains PLAY.
- o_score preset to 9999 via repeated coin edges -> further edges keep 9999. DEAD then i_start -> IDLE; next i_start -> PLAY with o_score=0.
- i_rst_n asserted mid-line during PLAY with o_score=5 -> asynchronously all outputs 0, o_is_finished=1. After release, the first v_sync edge with i_coin_scored=1 does not increment the score.
